// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG decoder feed controller:
// controller state encoding and the error codes reported on ErrCode.
package aq_djpeg_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRST,
      FEED,
      DRAIN,
      DONE,
      ERROR,
      ABORT
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_TIMEOUT = 2'd1;
   localparam logic [1:0] ERR_ABORT   = 2'd2;

   // States in which the decoder is actually consuming data.
   function automatic logic isActive(input state_t s);
      return (s == FEED) || (s == DRAIN);
   endfunction

endpackage

// File: rtl/aq_djpeg_skid.sv
// One-word holding buffer between the source stream and the decoder input.
// A load in the same cycle as a read replaces the word with no bubble.
module aq_djpeg_skid (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        load,
   input  logic [31:0] loadData,
   input  logic        read,
   output logic [31:0] data,
   output logic        valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         data  <= loadData;
         valid <= 1'b1;
      end else if (read) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/aq_djpeg_ctrl.sv
// Job controller feeding a JPEG decoder: decoder reset, word feed, drain
// detection, stall timeout, abort, pixel counting and interrupt.
module aq_djpeg_ctrl
   import aq_djpeg_pkg::*;
#(
   parameter int TIMEOUT_W = 24,
   parameter int RST_CYC   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 CmdStart,
   input  logic [23:0]          CmdLength,
   input  logic                 CmdAbort,
   input  logic [TIMEOUT_W-1:0] TimeoutLimit,
   input  logic [31:0]          SrcData,
   input  logic                 SrcValid,
   output logic                 SrcReady,
   output logic                 DecRst,
   output logic [31:0]          DataIn,
   output logic                 DataInEnable,
   input  logic                 DataInRead,
   input  logic                 DataInReq,
   input  logic                 JpegDecodeIdle,
   input  logic                 OutEnable,
   output logic                 Busy,
   output logic                 Done,
   output logic [1:0]           ErrCode,
   output logic [31:0]          PixelCount,
   output logic                 Irq,
   input  logic                 IrqClear
);

   localparam int RW = $clog2(RST_CYC + 1);

   state_t               state;
   logic [23:0]          wordsLeft;
   logic                 seenRun;
   logic [RW-1:0]        rstCnt;
   logic [TIMEOUT_W-1:0] stallCnt;
   logic [TIMEOUT_W-1:0] stallNext;
   logic                 errPulse;
   logic                 bufValid;
   logic                 active;
   logic                 load;
   logic                 startOk;
   logic                 abortOk;
   logic                 flush;
   logic                 timeoutHit;
   logic                 rstLast;

   assign active   = isActive(state);
   assign SrcReady = (state == FEED) && DataInReq && (wordsLeft != 24'd0) &&
                     (!bufValid || DataInRead);
   assign load     = SrcValid && SrcReady;
   assign startOk  = CmdStart && ((state == IDLE) || (state == DONE) || (state == ERROR));
   assign abortOk  = CmdAbort && ((state == DRST) || (state == FEED) || (state == DRAIN));
   assign flush    = startOk || abortOk;
   assign Busy     = (state == DRST) || (state == FEED) || (state == DRAIN) || (state == ABORT);
   assign rstLast  = (rstCnt == RW'(RST_CYC - 1));
   assign DataInEnable = bufValid;

   always_comb begin
      stallNext = stallCnt;
      if (load || OutEnable)
         stallNext = '0;
      else if (active && (stallCnt != '1))
         stallNext = stallCnt + TIMEOUT_W'(1);
   end

   // Timeout fires on the edge where the counter reaches the limit.
   assign timeoutHit = active && (TimeoutLimit != '0) && (stallNext == TimeoutLimit);

   aq_djpeg_skid uSkid (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .load     (load),
      .loadData (SrcData),
      .read     (DataInRead),
      .data     (DataIn),
      .valid    (bufValid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         wordsLeft  <= '0;
         seenRun    <= 1'b0;
         rstCnt     <= '0;
         stallCnt   <= '0;
         errPulse   <= 1'b0;
         DecRst     <= 1'b1;
         Done       <= 1'b0;
         ErrCode    <= ERR_NONE;
         PixelCount <= '0;
         Irq        <= 1'b0;
      end else begin
         Done     <= 1'b0;
         errPulse <= 1'b0;
         stallCnt <= stallNext;
         if (load)
            wordsLeft <= wordsLeft - 24'd1;
         if (active && !JpegDecodeIdle)
            seenRun <= 1'b1;
         if (active && OutEnable && (PixelCount != '1))
            PixelCount <= PixelCount + 32'd1;
         // Set from the entry pulses, so a clear coinciding with Done loses.
         if (Done || errPulse)
            Irq <= 1'b1;
         else if (IrqClear)
            Irq <= 1'b0;

         if (abortOk) begin
            state     <= ABORT;
            DecRst    <= 1'b1;
            rstCnt    <= '0;
            stallCnt  <= '0;
            wordsLeft <= '0;
         end else begin
            case (state)
               IDLE, DONE, ERROR: begin
                  DecRst <= 1'b0;
                  if (CmdStart) begin
                     wordsLeft  <= CmdLength;
                     PixelCount <= '0;
                     ErrCode    <= ERR_NONE;
                     seenRun    <= 1'b0;
                     stallCnt   <= '0;
                     rstCnt     <= '0;
                     if (CmdLength == 24'd0) begin
                        state <= DONE;
                        Done  <= 1'b1;
                     end else begin
                        state  <= DRST;
                        DecRst <= 1'b1;
                     end
                  end
               end
               DRST, ABORT: begin
                  if (rstLast) begin
                     DecRst   <= 1'b0;
                     stallCnt <= '0;
                     if (state == DRST) begin
                        state <= FEED;
                     end else begin
                        state    <= ERROR;
                        ErrCode  <= ERR_ABORT;
                        errPulse <= 1'b1;
                     end
                  end else begin
                     rstCnt <= rstCnt + RW'(1);
                  end
               end
               FEED: begin
                  if (timeoutHit) begin
                     state    <= ERROR;
                     ErrCode  <= ERR_TIMEOUT;
                     errPulse <= 1'b1;
                     stallCnt <= '0;
                  end else if ((wordsLeft == 24'd0) && !bufValid) begin
                     state    <= DRAIN;
                     stallCnt <= '0;
                  end
               end
               DRAIN: begin
                  if (seenRun && JpegDecodeIdle) begin
                     state    <= DONE;
                     Done     <= 1'b1;
                     stallCnt <= '0;
                  end else if (timeoutHit) begin
                     state    <= ERROR;
                     ErrCode  <= ERR_TIMEOUT;
                     errPulse <= 1'b1;
                     stallCnt <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aq_djpeg_ctrl.sv
// Directed bench for aq_djpeg_ctrl: a table of whole jobs plus hand-written
// sequences for reset, zero-length start, ignored abort and reset in DRAIN.
module tb_aq_djpeg_ctrl;
   import aq_djpeg_pkg::*;

   localparam int TW = 24;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          CmdStart;
   logic [23:0]   CmdLength;
   logic          CmdAbort;
   logic [TW-1:0] TimeoutLimit;
   logic [31:0]   SrcData;
   logic          SrcValid;
   logic          SrcReady;
   logic          DecRst;
   logic [31:0]   DataIn;
   logic          DataInEnable;
   logic          DataInRead;
   logic          DataInReq;
   logic          JpegDecodeIdle;
   logic          OutEnable;
   logic          Busy;
   logic          Done;
   logic [1:0]    ErrCode;
   logic [31:0]   PixelCount;
   logic          Irq;
   logic          IrqClear;

   always #5 clk = ~clk;

   aq_djpeg_ctrl #(.TIMEOUT_W(TW), .RST_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n), .CmdStart(CmdStart), .CmdLength(CmdLength),
      .CmdAbort(CmdAbort), .TimeoutLimit(TimeoutLimit), .SrcData(SrcData),
      .SrcValid(SrcValid), .SrcReady(SrcReady), .DecRst(DecRst), .DataIn(DataIn),
      .DataInEnable(DataInEnable), .DataInRead(DataInRead), .DataInReq(DataInReq),
      .JpegDecodeIdle(JpegDecodeIdle), .OutEnable(OutEnable), .Busy(Busy),
      .Done(Done), .ErrCode(ErrCode), .PixelCount(PixelCount), .Irq(Irq),
      .IrqClear(IrqClear)
   );

   typedef struct {
      int         len;
      int         tmo;
      int         outs;
      bit         tog;       // DataInReq toggles every 3 cycles
      bit         rnd;       // random SrcValid
      int         abortAt;   // abort once this many words are read (-1 none)
      int         rdStop;    // decoder stops reading after this many (-1 none)
      bit         clr;       // IrqClear driven during the Done cycle
      logic [1:0] expErr;
      int         expReads;
      int         expPix;
      int         expDecRst;
      int         expDone;
      int         expGap;    // cycles from last progress to ERROR visible
   } vec_t;

   vec_t vecs[6];
   int   checks = 0;
   int   fails  = 0;

   int jobLen, rdCount, srcIdx, outLeft, cyc, decRstCnt, doneCnt;
   int lastProg, errCyc, rdStop, abortAt, decHold;
   bit reqTog, srcRnd, clrOnDone, abortSent;
   logic [7:0] tag;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] word(input int i);
      return {8'hA5, tag, i[15:0]};
   endfunction

   // One clock cycle of source + decoder model: drive on negedge, sample 1ns before posedge.
   task automatic cycle();
      @(negedge clk);
      CmdStart       = 1'b0;
      CmdAbort       = (abortAt >= 0) && !abortSent && (rdCount == abortAt);
      if (CmdAbort) abortSent = 1'b1;
      SrcValid       = (srcIdx < jobLen) && (!srcRnd || ($urandom_range(0, 1) == 1));
      SrcData        = SrcValid ? word(srcIdx) : 32'hDEAD_BEEF;
      DataInReq      = reqTog ? (((cyc / 3) % 2) == 0) : 1'b1;
      DataInRead     = DataInEnable && !CmdAbort && ((rdStop < 0) || (rdCount < rdStop));
      OutEnable      = (outLeft > 0) && Busy && !DecRst;
      IrqClear       = clrOnDone && Done;
      JpegDecodeIdle = !((rdCount > 0) && ((rdCount < jobLen) || (outLeft > 0) || (decHold > 0)));
      #4;
      check("readyGate", {63'd0, SrcReady && !DataInReq}, 64'd0);
      if (SrcValid && SrcReady) begin
         srcIdx++;
         lastProg = cyc;
      end
      if (DataInRead && DataInEnable) begin
         check($sformatf("data[%0d]", rdCount), {32'd0, DataIn}, {32'd0, word(rdCount)});
         rdCount++;
         lastProg = cyc;
      end
      if (OutEnable) begin
         outLeft--;
         lastProg = cyc;
      end
      if (DecRst) decRstCnt++;
      if (Done) doneCnt++;
      if ((ErrCode == ERR_TIMEOUT) && (errCyc < 0)) errCyc = cyc;
      if ((rdCount == jobLen) && (outLeft == 0) && (decHold > 0)) decHold--;
      cyc++;
   endtask

   task automatic startJob(input vec_t v, input int id);
      jobLen = v.len; rdCount = 0; srcIdx = 0; outLeft = v.outs; cyc = 0;
      decRstCnt = 0; doneCnt = 0; lastProg = -1; errCyc = -1;
      rdStop = v.rdStop; abortAt = v.abortAt; decHold = 3;
      reqTog = v.tog; srcRnd = v.rnd; clrOnDone = v.clr; abortSent = 1'b0;
      tag = 8'(id);
      @(negedge clk);
      CmdStart     = 1'b1;
      CmdLength    = 24'(v.len);
      TimeoutLimit = TW'(v.tmo);
   endtask

   task automatic runJob(input int id);
      vec_t v;
      int   n;
      v = vecs[id];
      startJob(v, id);
      cycle();
      n = 1;
      while (Busy && (n < 3000)) begin
         cycle();
         n++;
      end
      check($sformatf("v%0d jobBound", id), {63'd0, n < 3000}, 64'd1);
      cycle();
      cycle();
      $display("job %0d: len=%0d reads=%0d err=%0d pix=%0d decRst=%0d done=%0d irq=%0d",
               id, v.len, rdCount, ErrCode, PixelCount, decRstCnt, doneCnt, Irq);
      check($sformatf("v%0d errCode", id), {62'd0, ErrCode}, {62'd0, v.expErr});
      check($sformatf("v%0d reads", id), 64'(rdCount), 64'(v.expReads));
      check($sformatf("v%0d pixelCount", id), {32'd0, PixelCount}, 64'(v.expPix));
      check($sformatf("v%0d decRstCycles", id), 64'(decRstCnt), 64'(v.expDecRst));
      check($sformatf("v%0d donePulses", id), 64'(doneCnt), 64'(v.expDone));
      check($sformatf("v%0d irq", id), {63'd0, Irq}, 64'd1);
      if (v.tmo != 0)
         check($sformatf("v%0d timeoutGap", id), 64'(errCyc - lastProg), 64'(v.expGap));
      @(negedge clk) IrqClear = 1'b1;
      @(negedge clk) IrqClear = 1'b0;
      #1 check($sformatf("v%0d irqCleared", id), {63'd0, Irq}, 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t d;
      //           len tmo outs tog rnd abt stop clr err          rd pix rst dn gap
      vecs[0] = '{16, 0,   0,  1'b0, 1'b0, -1, -1, 1'b0, ERR_NONE,    16, 0,  4, 1, 0};
      vecs[1] = '{20, 0,   0,  1'b1, 1'b1, -1, -1, 1'b0, ERR_NONE,    20, 0,  4, 1, 0};
      vecs[2] = '{8,  0,   64, 1'b0, 1'b0, -1, -1, 1'b1, ERR_NONE,    8,  64, 4, 1, 0};
      // 100 stalled cycles, ERROR registered on the edge ending the 100th
      vecs[3] = '{16, 100, 0,  1'b0, 1'b0, -1, 5,  1'b0, ERR_TIMEOUT, 5,  0,  4, 0, 101};
      vecs[4] = '{16, 0,   0,  1'b0, 1'b0, 3,  -1, 1'b0, ERR_ABORT,   3,  0,  8, 0, 0};
      vecs[5] = '{4,  0,   0,  1'b0, 1'b0, -1, -1, 1'b0, ERR_NONE,    4,  0,  4, 1, 0};

      rst_n = 1'b0; CmdStart = 1'b0; CmdLength = '0; CmdAbort = 1'b0; TimeoutLimit = '0;
      SrcData = '0; SrcValid = 1'b0; DataInRead = 1'b0; DataInReq = 1'b0;
      JpegDecodeIdle = 1'b1; OutEnable = 1'b0; IrqClear = 1'b0;
      jobLen = 0; rdCount = 0; srcIdx = 0; outLeft = 0; cyc = 0; decHold = 0;
      rdStop = -1; abortAt = -1; reqTog = 1'b0; srcRnd = 1'b0; clrOnDone = 1'b0;
      abortSent = 1'b0; tag = 8'd0;

      // Reset values while rst_n is held low
      #12;
      check("rst DecRst", {63'd0, DecRst}, 64'd1);
      check("rst Busy", {63'd0, Busy}, 64'd0);
      check("rst SrcReady", {63'd0, SrcReady}, 64'd0);
      check("rst Done", {63'd0, Done}, 64'd0);
      check("rst Irq", {63'd0, Irq}, 64'd0);
      check("rst ErrCode", {62'd0, ErrCode}, 64'd0);
      check("rst PixelCount", {32'd0, PixelCount}, 64'd0);
      check("rst DataIn", {32'd0, DataIn}, 64'd0);
      check("rst DataInEnable", {63'd0, DataInEnable}, 64'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk) #1;
      check("rst release DecRst", {63'd0, DecRst}, 64'd0);
      $display("reset sequence done");

      // Zero-length start goes straight to DONE
      @(negedge clk) begin CmdStart = 1'b1; CmdLength = 24'd0; end
      @(negedge clk) CmdStart = 1'b0;
      #1;
      check("len0 Done", {63'd0, Done}, 64'd1);
      check("len0 Busy", {63'd0, Busy}, 64'd0);
      check("len0 DecRst", {63'd0, DecRst}, 64'd0);
      @(negedge clk) #1;
      check("len0 DonePulse", {63'd0, Done}, 64'd0);
      check("len0 Irq", {63'd0, Irq}, 64'd1);
      @(negedge clk) IrqClear = 1'b1;
      @(negedge clk) IrqClear = 1'b0;
      #1 check("len0 IrqClear", {63'd0, Irq}, 64'd0);
      $display("zero-length job done");

      // Abort outside a job is ignored
      @(negedge clk) CmdAbort = 1'b1;
      @(negedge clk) CmdAbort = 1'b0;
      #1;
      check("idleAbort Busy", {63'd0, Busy}, 64'd0);
      check("idleAbort DecRst", {63'd0, DecRst}, 64'd0);
      check("idleAbort ErrCode", {62'd0, ErrCode}, 64'd0);
      $display("idle abort done");

      for (int i = 0; i < 6; i++)
         runJob(i);

      // Asynchronous reset while waiting in DRAIN
      d = '{2, 0, 5, 1'b0, 1'b0, -1, -1, 1'b0, ERR_NONE, 2, 5, 4, 0, 0};
      startJob(d, 9);
      decHold = 1000;
      repeat (30) cycle();
      check("drain Busy", {63'd0, Busy}, 64'd1);
      check("drain reads", 64'(rdCount), 64'd2);
      check("drain bufEmpty", {63'd0, DataInEnable}, 64'd0);
      check("drain PixelCount", {32'd0, PixelCount}, 64'd5);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midRst Busy", {63'd0, Busy}, 64'd0);
      check("midRst PixelCount", {32'd0, PixelCount}, 64'd0);
      check("midRst DecRst", {63'd0, DecRst}, 64'd1);
      check("midRst Done", {63'd0, Done}, 64'd0);
      jobLen = 0; decHold = 0; doneCnt = 0;
      @(negedge clk) rst_n = 1'b1;
      repeat (5) cycle();
      check("midRst noDone", 64'(doneCnt), 64'd0);
      check("midRst Irq", {63'd0, Irq}, 64'd0);
      check("midRst idle", {63'd0, Busy}, 64'd0);
      $display("reset in DRAIN done");

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/aq_djpeg_ctrl.md
AQ_DJPEG_CTRL -- requirements
Module: aq_djpeg_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_W, default 24, width of the stall-timeout counter and limit.
REQ-002 SHALL have parameter RST_CYC, default 4, number of cycles DecRst is held.
REQ-003 SHALL have ports clk input 1, the single clock; rst_n input 1, asynchronous active-low reset.
REQ-004 SHALL have ports CmdStart input 1, start pulse; CmdLength input 24, JPEG stream length in 32-bit words; CmdAbort input 1, abort pulse; TimeoutLimit input TIMEOUT_W, stall-cycle limit.
REQ-005 SHALL have ports SrcData input 32, SrcValid input 1 and SrcReady output 1, the source word stream.
REQ-006 SHALL have ports DecRst output 1, active-high decoder reset; DataIn output 32, DataInEnable output 1, DataInRead input 1, DataInReq input 1; JpegDecodeIdle input 1; OutEnable input 1.
REQ-007 SHALL have ports Busy output 1; Done output 1 (pulse); ErrCode output 2 (0 none, 1 timeout, 2 abort); PixelCount output 32; Irq output 1; IrqClear input 1.

Function
REQ-008 SHALL implement states IDLE, DRST, FEED, DRAIN, DONE, ERROR, ABORT.
REQ-009 From IDLE, DONE or ERROR, CmdStart SHALL latch CmdLength into WordsLeft, clear PixelCount, ErrCode and SeenRun, and enter DRST; CmdStart in any other state SHALL be ignored.
REQ-010 If CmdStart arrives with CmdLength=0, the block SHALL enter DONE directly, pulse Done and set Irq.
REQ-011 DRST SHALL assert DecRst for exactly RST_CYC cycles, then enter FEED.
REQ-012 The block SHALL hold a one-word buffer: DataIn = buffer; DataInEnable = buffer valid.
REQ-013 In FEED: SrcReady = DataInReq & WordsLeft!=0 & (!bufvalid | DataInRead).
REQ-014 A word SHALL be loaded when SrcValid & SrcReady; each load decrements WordsLeft by 1.
REQ-015 DataInRead with bufvalid set and no load in the same cycle SHALL clear bufvalid; a simultaneous read and load SHALL keep bufvalid set with the new word, with zero bubble.
REQ-016 SrcReady SHALL be 0 in every state other than FEED.
REQ-017 FEED SHALL go to DRAIN when WordsLeft=0 and bufvalid=0.
REQ-018 SeenRun SHALL set when JpegDecodeIdle=0 in FEED or DRAIN.
REQ-019 DRAIN SHALL go to DONE when SeenRun=1 and JpegDecodeIdle=1.
REQ-020 Entering DONE SHALL produce a one-cycle Done pulse.
REQ-021 PixelCount SHALL increment by 1 on every OutEnable cycle in FEED or DRAIN, saturating at 0xFFFFFFFF.
REQ-022 A stall counter SHALL clear on any load, any OutEnable, or any state change, and otherwise increment in FEED or DRAIN.
REQ-023 When the stall counter equals TimeoutLimit (nonzero), the block SHALL enter ERROR with ErrCode=1; TimeoutLimit=0 SHALL disable the timeout.
REQ-024 CmdAbort in DRST, FEED or DRAIN SHALL flush the buffer and enter ABORT.
REQ-025 ABORT SHALL assert DecRst for RST_CYC cycles, then enter ERROR with ErrCode=2.
REQ-026 CmdAbort SHALL take priority over timeout and completion in the same cycle.
REQ-027 CmdAbort in IDLE, DONE or ERROR SHALL be ignored.
REQ-028 Busy SHALL be 1 in DRST, FEED, DRAIN and ABORT.
REQ-029 Irq SHALL set on entry to DONE or ERROR and clear on IrqClear; simultaneous set and clear SHALL leave it set.

Reset
REQ-030 On rst_n low, the block SHALL enter IDLE asynchronously.
REQ-031 On rst_n low, all counters, buffer-valid, Done, Irq, ErrCode, PixelCount and SrcReady SHALL be 0, and DataIn SHALL be 0.
REQ-032 During rst_n low, DecRst SHALL be 1; on release it SHALL deassert on the first clock edge.
REQ-033 Reset mid-job SHALL discard all job state with no Done and no Irq.

Structure
REQ-034 A shared package aq_djpeg_pkg SHALL hold the state encoding and the ErrCode constants (ERR_NONE, ERR_TIMEOUT, ERR_ABORT).
REQ-035 The word buffer SHALL be one sub-module, aq_djpeg_skid; the FSM, counters and IRQ logic stay in aq_djpeg_ctrl.

Verification
REQ-036 Scenario: CmdLength=16, source and decoder always ready, decoder model drops idle then raises it -> 16 DataInRead handshakes with data matching, DecRst high for 4 cycles, one Done pulse, Irq=1, ErrCode=0.
REQ-037 Scenario: DataInReq toggling every 3 cycles, SrcValid random -> word order preserved, no word lost or duplicated, SrcReady=0 whenever DataInReq=0.
REQ-038 Scenario: TimeoutLimit=100, decoder stops reading after word 5 -> ERROR exactly 100 cycles after the last progress, ErrCode=1, Irq=1.
REQ-039 Scenario: CmdAbort in FEED after word 3 -> DecRst high 4 cycles, then ERROR with ErrCode=2; a new CmdStart then restarts cleanly.
REQ-040 Scenario: 64 OutEnable pulses during the job and IrqClear in the same cycle as Done -> PixelCount=64, Irq remains 1.
REQ-041 Scenario: rst_n low in DRAIN -> IDLE immediately, Busy=0, PixelCount=0, no Done pulse.
